countdown_timer: RTL

Count-down counterpart of the stopwatch mode: loads a preset hours/minutes/seconds value, then decrements it once per 1 Hz tick until it reaches 0:00:00 and raises an alarm. It sits beside the stopwatch in the mode datapath. It shares the same 1 Hz prescaler tick, and its hours_o/mins_o/secs_o feed the display mux through the same output formats as the stopwatch.

---
 rtl/countdown_timer.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module   : countdown_timer
//  Purpose  : Preset hours/minutes/seconds count-down timer. A preset is
//             captured on load, then decremented once per 1 Hz tick while
//             running. When the count reaches 0:00:00 the alarm (done_o)
//             is raised. The alarm clears on ack or, optionally, on its own
//             after a programmable number of ticks.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    MAX_HOURS  : upper clamp for the loaded hours value (must fit 0..31)
//    ALARM_SECS : ticks spent in ALARM before self-clear; 0 = hold until ack
//
//  Build option
//    COUNTDOWN_AUTO_RELOAD_EN : when defined, the decrement that would reach
//                               0:00:00 reloads the preset instead, done_o
//                               pulses for one cycle and the timer keeps
//                               running. ALARM is never entered.
//
//  Ports
//    clk        in   1  system clock, rising edge
//    reset      in   1  asynchronous reset, active low
//    tick       in   1  single-cycle 1 Hz enable
//    load       in   1  capture hours_i/mins_i/secs_i as preset and count
//    start      in   1  toggle run/pause
//    ack        in   1  acknowledge the alarm
//    hours_i    in   5  preset hours
//    mins_i     in   6  preset minutes
//    secs_i     in   6  preset seconds
//    hours_o    out  5  remaining hours
//    mins_o     out  6  remaining minutes
//    secs_o     out  6  remaining seconds
//    running_o  out  1  high while counting down
//    done_o     out  1  alarm indication
// ============================================================================

module countdown_timer #(
    parameter int MAX_HOURS  = 23,
    parameter int ALARM_SECS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic       start,
    input  logic       ack,
    input  logic [4:0] hours_i,
    input  logic [5:0] mins_i,
    input  logic [5:0] secs_i,
    output logic [4:0] hours_o,
    output logic [5:0] mins_o,
    output logic [5:0] secs_o,
    output logic       running_o,
    output logic       done_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [4:0] HOURS_CAP   = 5'(MAX_HOURS);
    localparam logic [5:0] SIXTY_MINUS = 6'd59;

    // The alarm counter runs 0 .. ALARM_SECS-1; reaching the last value on a
    // tick is the ALARM_SECS-th tick, which triggers the self-clear.
    localparam int              ACW         = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
    localparam logic [ACW-1:0]  ALARM_LAST  = (ALARM_SECS > 0) ? ACW'(ALARM_SECS - 1) : '0;
    localparam bit              ALARM_TIMED = (ALARM_SECS != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        ALARM  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t           state;
    logic [4:0]       preset_hours;
    logic [5:0]       preset_mins;
    logic [5:0]       preset_secs;
    logic [ACW-1:0]   alarm_cnt;

    // ------------------------------------------------------------------------
    // Load clamping
    // ------------------------------------------------------------------------
    logic [4:0] load_hours;
    logic [5:0] load_mins;
    logic [5:0] load_secs;

    always_comb begin
        load_hours = (hours_i > HOURS_CAP)   ? HOURS_CAP   : hours_i;
        load_mins  = (mins_i  > SIXTY_MINUS) ? SIXTY_MINUS : mins_i;
        load_secs  = (secs_i  > SIXTY_MINUS) ? SIXTY_MINUS : secs_i;
    end

    // ------------------------------------------------------------------------
    // One-second decrement with borrow from minutes and hours
    // ------------------------------------------------------------------------
    logic [4:0] dec_hours;
    logic [5:0] dec_mins;
    logic [5:0] dec_secs;
    logic       dec_zero;
    logic       count_zero;

    always_comb begin
        dec_hours = hours_o;
        dec_mins  = mins_o;
        dec_secs  = secs_o;
        if (secs_o != 6'd0) begin
            dec_secs = secs_o - 6'd1;
        end else if (mins_o != 6'd0) begin
            dec_secs = SIXTY_MINUS;
            dec_mins = mins_o - 6'd1;
        end else if (hours_o != 5'd0) begin
            dec_secs  = SIXTY_MINUS;
            dec_mins  = SIXTY_MINUS;
            dec_hours = hours_o - 5'd1;
        end
    end

    assign dec_zero   = (dec_hours == 5'd0) && (dec_mins == 6'd0) && (dec_secs == 6'd0);
    assign count_zero = (hours_o   == 5'd0) && (mins_o   == 6'd0) && (secs_o   == 6'd0);

    // ------------------------------------------------------------------------
    // Control FSM and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            preset_hours <= 5'd0;
            preset_mins  <= 6'd0;
            preset_secs  <= 6'd0;
            hours_o      <= 5'd0;
            mins_o       <= 6'd0;
            secs_o       <= 6'd0;
            running_o    <= 1'b0;
            done_o       <= 1'b0;
            alarm_cnt    <= '0;
        end else if (load) begin
            // load overrides everything else, in every state
            preset_hours <= load_hours;
            preset_mins  <= load_mins;
            preset_secs  <= load_secs;
            hours_o      <= load_hours;
            mins_o       <= load_mins;
            secs_o       <= load_secs;
            state        <= IDLE;
            running_o    <= 1'b0;
            done_o       <= 1'b0;
            alarm_cnt    <= '0;
        end else begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            // done_o is a single-cycle pulse in this build
            done_o <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // a start with nothing left to count is ignored
                    if (start && !count_zero) begin
                        state     <= RUN;
                        running_o <= 1'b1;
                    end
                end

                RUN: begin
                    if (start) begin
                        // pause wins over a coincident tick
                        state     <= PAUSED;
                        running_o <= 1'b0;
                    end else if (tick) begin
                        if (dec_zero) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            hours_o <= preset_hours;
                            mins_o  <= preset_mins;
                            secs_o  <= preset_secs;
                            done_o  <= 1'b1;
`else
                            hours_o   <= 5'd0;
                            mins_o    <= 6'd0;
                            secs_o    <= 6'd0;
                            state     <= ALARM;
                            running_o <= 1'b0;
                            done_o    <= 1'b1;
                            alarm_cnt <= '0;
`endif
                        end else begin
                            hours_o <= dec_hours;
                            mins_o  <= dec_mins;
                            secs_o  <= dec_secs;
                        end
                    end
                end

                PAUSED: begin
                    // resume wins over a coincident tick; no decrement here
                    if (start) begin
                        state     <= RUN;
                        running_o <= 1'b1;
                    end
                end

                ALARM: begin
                    // start is ignored; ack and the self-clear both reload
                    if (ack || (ALARM_TIMED && tick && (alarm_cnt == ALARM_LAST))) begin
                        hours_o   <= preset_hours;
                        mins_o    <= preset_mins;
                        secs_o    <= preset_secs;
                        state     <= IDLE;
                        done_o    <= 1'b0;
                        alarm_cnt <= '0;
                    end else if (ALARM_TIMED && tick) begin
                        alarm_cnt <= alarm_cnt + 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    running_o <= 1'b0;
                    done_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
